// File: rtl/shot_sequencer.sv
// Multi-shot run controller: issues one stb_shot per shot, waits for shot_done, idles shotgap cycles between shots.
// Optional per-shot watchdog enabled by defining SHOTSEQ_TIMEOUT_EN.
module shot_sequencer #(
  parameter int NSHOTWIDTH   = 32,
  parameter int GAPWIDTH     = 16,
  parameter int TIMEOUTWIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stb_start,
  input  logic                    stb_abort,
  input  logic [NSHOTWIDTH-1:0]   nshot,
  input  logic [GAPWIDTH-1:0]     shotgap,
  input  logic                    resetacc,
  input  logic [TIMEOUTWIDTH-1:0] timeout,
  input  logic                    shot_done,
  output logic                    stb_shot,
  output logic                    acc_clr,
  output logic                    busy,
  output logic [NSHOTWIDTH-1:0]   shotcnt,
  output logic                    lastshotdone,
  output logic                    aborted,
  output logic                    timedout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]            state;
  logic [NSHOTWIDTH-1:0] nshot_l;
  logic [GAPWIDTH-1:0]   gap_l;
  logic [GAPWIDTH-1:0]   gap_cnt;
  logic                  resetacc_l;
  logic [NSHOTWIDTH-1:0] cnt_inc;

  assign cnt_inc = shotcnt + 1'b1;

`ifdef SHOTSEQ_TIMEOUT_EN
  logic [TIMEOUTWIDTH-1:0] wdog;
  logic [TIMEOUTWIDTH:0]   wdog_inc;
  logic                    wdog_expire;

  // wdog counts WAIT cycles already elapsed; expiry fires in the timeout-th WAIT cycle
  assign wdog_inc    = {1'b0, wdog} + 1'b1;
  assign wdog_expire = (timeout != '0) && (wdog_inc == {1'b0, timeout});
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign timedout       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      nshot_l      <= '0;
      gap_l        <= '0;
      gap_cnt      <= '0;
      resetacc_l   <= 1'b0;
      stb_shot     <= 1'b0;
      acc_clr      <= 1'b0;
      busy         <= 1'b0;
      shotcnt      <= '0;
      lastshotdone <= 1'b0;
      aborted      <= 1'b0;
`ifdef SHOTSEQ_TIMEOUT_EN
      timedout     <= 1'b0;
      wdog         <= '0;
`endif
    end else begin
      stb_shot <= 1'b0;
      acc_clr  <= 1'b0;
      case (state)
        IDLE: begin
          // abort is ignored here, so a coincident start simply wins
          if (stb_start) begin
            nshot_l      <= nshot;
            gap_l        <= shotgap;
            resetacc_l   <= resetacc;
            shotcnt      <= '0;
            lastshotdone <= 1'b0;
            aborted      <= 1'b0;
`ifdef SHOTSEQ_TIMEOUT_EN
            timedout     <= 1'b0;
`endif
            if (nshot == '0) begin
              lastshotdone <= 1'b1;
            end else begin
              state    <= FIRE;
              busy     <= 1'b1;
              stb_shot <= 1'b1;
              acc_clr  <= resetacc;
            end
          end
        end
        FIRE: begin
          if (stb_abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state <= WAIT;
`ifdef SHOTSEQ_TIMEOUT_EN
            wdog  <= '0;
`endif
          end
        end
        WAIT: begin
          if (stb_abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (shot_done) begin
            shotcnt <= cnt_inc;
            if (cnt_inc == nshot_l) begin
              state        <= IDLE;
              busy         <= 1'b0;
              lastshotdone <= 1'b1;
            end else if (gap_l == '0) begin
              state    <= FIRE;
              stb_shot <= 1'b1;
              acc_clr  <= resetacc_l && (cnt_inc == '0);
            end else begin
              state   <= GAP;
              gap_cnt <= gap_l;
            end
`ifdef SHOTSEQ_TIMEOUT_EN
          end else if (wdog_expire) begin
            state    <= IDLE;
            busy     <= 1'b0;
            timedout <= 1'b1;
          end else begin
            wdog <= wdog_inc[TIMEOUTWIDTH-1:0];
`endif
          end
        end
        GAP: begin
          if (stb_abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (gap_cnt == GAPWIDTH'(1)) begin
            state    <= FIRE;
            stb_shot <= 1'b1;
            acc_clr  <= resetacc_l && (shotcnt == '0);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: a responder returns shot_done a fixed delay after each stb_shot.
module tb_shot_sequencer;
  localparam int NW = 32;
  localparam int GW = 16;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stb_start = 1'b0;
  logic          stb_abort = 1'b0;
  logic          resetacc = 1'b0;
  logic          man_done = 1'b0;
  logic [NW-1:0] nshot = '0;
  logic [GW-1:0] shotgap = '0;
  logic [TW-1:0] timeout = '0;
  logic          shot_done;
  logic          stb_shot, acc_clr, busy, lastshotdone, aborted, timedout;
  logic [NW-1:0] shotcnt;

  bit auto_en = 1'b0;
  bit auto_done;
  int dcnt;
  int n_shot, n_clr;
  int n_chk = 0, n_fail = 0, cyc = 0, s0 = 0, c0 = 0;

  assign shot_done = man_done | auto_done;

  shot_sequencer #(.NSHOTWIDTH(NW), .GAPWIDTH(GW), .TIMEOUTWIDTH(TW)) dut (
    .clk(clk), .reset(reset), .stb_start(stb_start), .stb_abort(stb_abort),
    .nshot(nshot), .shotgap(shotgap), .resetacc(resetacc), .timeout(timeout),
    .shot_done(shot_done), .stb_shot(stb_shot), .acc_clr(acc_clr), .busy(busy),
    .shotcnt(shotcnt), .lastshotdone(lastshotdone), .aborted(aborted), .timedout(timedout)
  );

  always #5 clk = ~clk;

  // DSP core model: shot_done 5 cycles after each stb_shot; also counts issued pulses
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (stb_shot && auto_en) dcnt = 5;
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) auto_done = 1'b1;
    end
    if (!reset) begin
      if (stb_shot) n_shot++;
      if (acc_clr) n_clr++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse_start();
    stb_start = 1'b1;
    tick();
    stb_start = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_outs", {stb_shot, acc_clr, busy, lastshotdone, aborted, timedout}, 0);
    chk("reset_cnt", shotcnt, 0);
    tick(); tick();
    reset = 1'b0;

    // three shots, gap 0, accumulator clear on first shot only
    nshot = 3; shotgap = 0; resetacc = 1; auto_en = 1;
    s0 = n_shot; c0 = n_clr; cyc = 0;
    pulse_start();
    chk("t1_stb1", stb_shot, 1);
    chk("t1_clr1", acc_clr, 1);
    chk("t1_busy", busy, 1);
    run_to(6);  chk("t1_cnt0", shotcnt, 0);
    run_to(7);  chk("t1_cnt1", shotcnt, 1); chk("t1_stb2", stb_shot, 1); chk("t1_clr2", acc_clr, 0);
    run_to(13); chk("t1_cnt2", shotcnt, 2); chk("t1_stb3", stb_shot, 1);
    run_to(18); chk("t1_busy18", busy, 1); chk("t1_lsd18", lastshotdone, 0);
    run_to(19); chk("t1_cnt3", shotcnt, 3); chk("t1_lsd", lastshotdone, 1); chk("t1_idle", busy, 0);
    chk("t1_tmo", timedout, 0);
    run_to(21);
    chk("t1_nshots", n_shot - s0, 3);
    chk("t1_nclr", n_clr - c0, 1);

    // two shots with gap 4; stray shot_done in GAP; start in finishing cycle
    nshot = 2; shotgap = 4; resetacc = 0; s0 = n_shot; cyc = 0;
    pulse_start();
    chk("t2_stb1", stb_shot, 1); chk("t2_clr", acc_clr, 0); chk("t2_lsdclr", lastshotdone, 0);
    run_to(7);  chk("t2_cnt1", shotcnt, 1); chk("t2_gap_stb", stb_shot, 0);
    man_done = 1'b1; tick(); man_done = 1'b0;
    run_to(10); chk("t2_stray", shotcnt, 1); chk("t2_stb10", stb_shot, 0);
    run_to(11); chk("t2_stb2", stb_shot, 1);
    run_to(16);
    stb_start = 1'b1; tick(); stb_start = 1'b0;
    chk("t2_lsd", lastshotdone, 1); chk("t2_idle", busy, 0); chk("t2_cnt2", shotcnt, 2);
    tick();
    chk("t2_nostart", busy, 0); chk("t2_nostb", stb_shot, 0);
    chk("t2_nshots", n_shot - s0, 2);

    // abort coincident with shot 2 of 5; start mid-run ignored
    nshot = 5; shotgap = 0; resetacc = 1; s0 = n_shot; cyc = 0;
    pulse_start();
    run_to(4);
    nshot = 1; stb_start = 1'b1; tick(); stb_start = 1'b0; nshot = 5;
    chk("t3_busy", busy, 1);
    run_to(7);  chk("t3_cnt1", shotcnt, 1);
    run_to(12);
    stb_abort = 1'b1; tick(); stb_abort = 1'b0;
    chk("t3_cnt", shotcnt, 1); chk("t3_abt", aborted, 1);
    chk("t3_idle", busy, 0);   chk("t3_lsd", lastshotdone, 0);
    run_to(16); chk("t3_nshots", n_shot - s0, 2);

    // nshot 0: immediate completion, flags cleared, abort in IDLE ignored
    nshot = 0; s0 = n_shot; cyc = 0;
    pulse_start();
    chk("t4_lsd", lastshotdone, 1); chk("t4_abtclr", aborted, 0);
    chk("t4_busy", busy, 0);        chk("t4_stb", stb_shot, 0);
    tick(); chk("t4_busy2", busy, 0);
    stb_abort = 1'b1; tick(); stb_abort = 1'b0;
    chk("t4_idleabt", aborted, 0);
    chk("t4_nshots", n_shot - s0, 0);

    // start and abort together in IDLE: start wins
    nshot = 1; resetacc = 0; cyc = 0;
    stb_start = 1'b1; stb_abort = 1'b1; tick(); stb_start = 1'b0; stb_abort = 1'b0;
    chk("t5_busy", busy, 1); chk("t5_stb", stb_shot, 1); chk("t5_abt", aborted, 0);
    run_to(7);
    chk("t5_lsd", lastshotdone, 1); chk("t5_cnt", shotcnt, 1); chk("t5_idle", busy, 0);

    // async reset while in GAP
    nshot = 2; shotgap = 20; resetacc = 1; cyc = 0;
    pulse_start();
    run_to(9); chk("t6_busy", busy, 1); chk("t6_cnt", shotcnt, 1);
    reset = 1'b1; #1;
    chk("t6_outs", {stb_shot, acc_clr, busy, lastshotdone, aborted, timedout}, 0);
    chk("t6_cnt0", shotcnt, 0);
    tick(); reset = 1'b0;
    s0 = n_shot;
    repeat (30) tick();
    chk("t6_nostb", n_shot - s0, 0); chk("t6_idle", busy, 0);

`ifdef SHOTSEQ_TIMEOUT_EN
    // watchdog: no shot_done, timeout 10
    auto_en = 0; nshot = 1; timeout = 10; cyc = 0;
    pulse_start();
    run_to(11); chk("t7_pre", timedout, 0); chk("t7_busy", busy, 1);
    tick();
    chk("t7_tmo", timedout, 1); chk("t7_idle", busy, 0);
    chk("t7_lsd", lastshotdone, 0); chk("t7_cnt", shotcnt, 0);
    timeout = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
